// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Write-port controller for the 32x32 register file. Shares the
//             single write port between the ALU and the load unit using
//             valid/ready handshakes and round-robin arbitration. Writes to
//             x0 are consumed but never issued. Optionally sweeps every
//             register to zero after reset.
//
//  Build macro : REGFILE_CLEAR_EN
//                defined   -> CLEAR/RUN state machine with an NREG-cycle
//                             zero sweep after reset (busy high meanwhile)
//                undefined -> no sweep, no counter; RUN straight out of
//                             reset and busy tied low
//
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-high reset
//             alu_valid  ALU writeback request
//             alu_rd     ALU destination register
//             alu_data   ALU result
//             alu_ready  ALU request accepted this cycle
//             mem_valid  load-unit writeback request
//             mem_rd     load destination register
//             mem_data   load data
//             mem_ready  load request accepted this cycle
//             wb_we      register-file write enable   (registered)
//             wb_addr    register-file write address  (registered)
//             wb_data    register-file write data     (registered)
//             busy       clear sweep in progress
//
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          busy
);

    // ------------------------------------------------------------------
    // Shared signals
    // ------------------------------------------------------------------
    logic          w_run;        // arbitration enabled
    logic          w_clr_we;     // sweep write this edge
    logic [AW-1:0] w_clr_addr;   // sweep address for this edge

    logic          r_last_mem;   // 1: the load unit was granted last
    logic          w_alu_gnt;
    logic          w_mem_gnt;
    logic          w_xfer;
    logic [AW-1:0] w_sel_rd;
    logic [DW-1:0] w_sel_data;

    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

`ifdef REGFILE_CLEAR_EN
    // ------------------------------------------------------------------
    // Clear-sweep state machine
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREG - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                // The counter parks on the last index rather than wrapping,
                // so a second sweep can only start from a fresh reset.
                if (r_cnt == c_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_run      = (r_state == ST_RUN);
    assign w_clr_addr = r_cnt;
    assign busy       = (r_state == ST_CLEAR);
`else
    assign w_run      = 1'b1;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
    assign busy       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Round-robin grant. A lone requester always wins; on a tie the one
    // that was not granted last time wins. The pointer only moves on an
    // actual transfer, so idle cycles leave the priority untouched.
    // ------------------------------------------------------------------
    assign w_alu_gnt = w_run & alu_valid & (~mem_valid | r_last_mem);
    assign w_mem_gnt = w_run & mem_valid & (~alu_valid | ~r_last_mem);

    // Readies are held low for the whole time reset is asserted, even
    // though the grant path itself is purely combinational.
    assign alu_ready = ~rst & w_alu_gnt;
    assign mem_ready = ~rst & w_mem_gnt;

    assign w_xfer     = alu_ready | mem_ready;
    assign w_sel_rd   = w_mem_gnt ? mem_rd   : alu_rd;
    assign w_sel_data = w_mem_gnt ? mem_data : alu_data;

    // ------------------------------------------------------------------
    // Registered write port and arbitration pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_last_mem <= 1'b1;   // ALU wins the first tie after reset
        end else if (w_clr_we) begin
            r_we   <= 1'b1;
            r_addr <= w_clr_addr;
            r_data <= '0;
        end else if (w_xfer) begin
            // An x0 destination is accepted and moves the pointer, but
            // never reaches the register file.
            r_we       <= (w_sel_rd != '0);
            r_addr     <= w_sel_rd;
            r_data     <= w_sel_data;
            r_last_mem <= w_mem_gnt;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign wb_we   = r_we;
    assign wb_addr = r_addr;
    assign wb_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter. A behavioural model
//             (sweep counter, tie pointer, expected write) is compared with
//             the DUT on every falling edge; directed sequences pin the model
//             with literal expectations; a randomized phase follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef REGFILE_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd    = '0;
    logic [DW-1:0] alu_data  = '0;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_rd    = '0;
    logic [DW-1:0] mem_data  = '0;
    wire           alu_ready;
    wire           mem_ready;
    wire           wb_we;
    wire  [AW-1:0] wb_addr;
    wire  [DW-1:0] wb_data;
    wire           busy;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int            m_clear_left = 0;   // zero writes still to issue
    int            m_clear_addr = 0;
    bit            m_last_mem   = 1'b1;
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    // {mem granted, alu granted} for the current inputs
    function automatic logic [1:0] model_grant();
        if (rst !== 1'b0 || m_clear_left > 0) return 2'b00;
        if (alu_valid && mem_valid) return m_last_mem ? 2'b01 : 2'b10;
        if (alu_valid) return 2'b01;
        if (mem_valid) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] g;
        if (rst) begin
            m_clear_left = CLR ? NREG : 0;
            m_clear_addr = 0;
            m_last_mem   = 1'b1;
            m_we         = 1'b0;
            m_addr       = '0;
            m_data       = '0;
        end else if (m_clear_left > 0) begin
            m_we         = 1'b1;
            m_addr       = AW'(m_clear_addr);
            m_data       = '0;
            m_clear_addr = m_clear_addr + 1;
            m_clear_left = m_clear_left - 1;
        end else begin
            g = model_grant();
            if (g[0]) begin
                m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data; m_last_mem = 1'b0;
            end else if (g[1]) begin
                m_we = (mem_rd != 0); m_addr = mem_rd; m_data = mem_data; m_last_mem = 1'b1;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        g = model_grant();
        chk("alu_ready", alu_ready, g[0]);
        chk("mem_ready", mem_ready, g[1]);
        chk("wb_we",     wb_we,     m_we);
        chk("wb_addr",   wb_addr,   m_addr);
        chk("wb_data",   wb_data,   m_data);
        chk("busy",      busy,      m_clear_left > 0);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit found;
        bit sa, sm;
        int exp_k;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000000A;

        // Reset values, with a request already pending
        @(negedge clk);
        chk("rst_wb_we",     wb_we,     0);
        chk("rst_wb_addr",   wb_addr,   0);
        chk("rst_wb_data",   wb_data,   0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_busy",      busy,      CLR);

        // Release: sweep (if built in), then the ALU request is granted
        @(posedge clk); #1 rst = 1'b0;
`ifdef REGFILE_CLEAR_EN
        exp_k = NREG;
`else
        exp_k = 0;
`endif
        found = 1'b0;
        for (int k = 0; k < NREG + 8 && !found; k++) begin
            @(negedge clk);
`ifdef REGFILE_CLEAR_EN
            if (k >= 1 && k <= NREG) begin
                chk("sweep_we",   wb_we,   1);
                chk("sweep_addr", wb_addr, 64'(k - 1));
                chk("sweep_data", wb_data, 0);
            end
            if (k < NREG) chk("sweep_busy", busy, 1);
`else
            chk("noclr_busy", busy, 0);
`endif
            if (alu_ready) begin
                found = 1'b1;
                chk("first_grant_cycle", 64'(k), 64'(exp_k));
            end
        end
        if (!found) chk("alu_ready_timeout", alu_ready, 1);

        // Single requester: write appears one cycle after the handshake
        @(posedge clk); #1 alu_valid = 1'b0;
        @(negedge clk);
        chk("single_we",   wb_we,   1);
        chk("single_addr", wb_addr, 5);
        chk("single_data", wb_data, 32'h0000000A);
        @(negedge clk);
        chk("single_we_drop", wb_we, 0);

        // x0 destination: consumed, never written
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("x0_mem_ready", mem_ready, 1);
        chk("x0_alu_ready", alu_ready, 0);

        // Contention: both valid every cycle, ALU wins the first tie
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        @(negedge clk);
        chk("x0_no_write", wb_we, 0);
        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] ea;
            if (i > 0) @(negedge clk);
            chk("cont_alu_ready", alu_ready, (i % 2) == 0);
            chk("cont_mem_ready", mem_ready, (i % 2) == 1);
            if (i > 0) begin
                ea = ((i % 2) == 1) ? 5'd6 : 5'd7;
                chk("cont_we",   wb_we,   1);
                chk("cont_addr", wb_addr, ea);
            end
        end

        // Reset mid-transfer: the pending write disappears immediately
        #1 rst = 1'b1;
        #1;
        chk("async_rst_we",        wb_we,     0);
        chk("async_rst_alu_ready", alu_ready, 0);
        chk("async_rst_mem_ready", mem_ready, 0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

`ifdef REGFILE_CLEAR_EN
        // Reset mid-sweep at address 12, then a complete restart from 0
        found = 1'b0;
        for (int k = 0; k < NREG + 4 && !found; k++) begin
            @(negedge clk);
            if (wb_we && wb_addr == 5'd12) found = 1'b1;
        end
        if (!found) chk("sweep12_timeout", wb_addr, 12);
        #1 rst = 1'b1;
        #1 chk("sweep_rst_we", wb_we, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k <= NREG + 1; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= NREG) begin
                chk("resweep_we",   wb_we,   1);
                chk("resweep_addr", wb_addr, 64'(k - 1));
            end
        end
        chk("resweep_end_we", wb_we, 0);
`else
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("noclr_no_zero_write", wb_we, 0);
            chk("noclr_busy_low",      busy,  0);
        end
`endif

        // Randomized traffic with the hold-until-ready discipline
        sa = 1'b0; sm = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            sa = alu_ready; sm = mem_ready;
            @(posedge clk);
            #1;
            if (!alu_valid || sa) begin
                alu_valid = ($urandom % 3) != 0;
                alu_rd    = (($urandom % 4) == 0) ? '0 : AW'($urandom);
                alu_data  = $urandom;
            end
            if (!mem_valid || sm) begin
                mem_valid = ($urandom % 3) != 0;
                mem_rd    = (($urandom % 4) == 0) ? '0 : AW'($urandom);
                mem_data  = $urandom;
            end
            rst = (($urandom % 400) == 0);
        end
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32×32 register file. It shares the file's single write port (address, data, write-enable) between two writeback requesters, the ALU and the load unit, using valid/ready handshakes and round-robin arbitration. It suppresses writes to x0 and, when configured, sweeps all registers to zero after reset. It sits between the execute/memory stages and the register file write port; read ports are untouched.

## Interface
- NREG, 32, number of registers, a power of two
- AW, 5, register address width, log2(NREG)
- DW, 32, data width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load-unit writeback request
- mem_rd  in  AW  load destination register
- mem_data  in  DW  load data
- mem_ready  out  1  load request accepted this cycle
- wb_we  out  1  register-file write enable, registered
- wb_addr  out  AW  register-file write address, registered
- wb_data  out  DW  register-file write data, registered
- busy  out  1  clear sweep in progress

## Operation
- States: CLEAR and RUN. Reset forces CLEAR when REGFILE_CLEAR_EN is defined, and RUN otherwise.
- CLEAR:
  - At each clock edge, load wb_we=1, wb_addr=cnt, wb_data=0, then increment cnt.
  - After the edge that loads cnt=NREG-1, go to RUN. cnt does not wrap into a second sweep.
  - alu_ready and mem_ready are 0. busy is 1.
- RUN grant logic (combinational from the valids and the pointer):
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
  - Neither valid: no grant, and the pointer holds.
- The granted requester's ready is 1. A transfer occurs when valid and ready are both 1.
- Requesters must hold valid, rd and data stable until ready is seen.
- On a transfer, at the next edge:
  - wb_addr and wb_data load the granted rd and data.
  - wb_we loads 1, or 0 if rd==0.
  - The pointer records the granted requester.
- A transfer to x0 is consumed normally: ready pulses and the pointer updates, but no write is issued.
- With no transfer, wb_we loads 0. wb_addr and wb_data hold.
- At most one write per cycle. Sustained throughput is one write per cycle. Both-valid traffic alternates ALU, MEM, ALU, ...
- Reset pointer state is "last = MEM", so the ALU wins the first tie.

## Timing
- Reset values: wb_we=0, wb_addr=0, wb_data=0, alu_ready=0, mem_ready=0, pointer=MEM-last, cnt=0. busy=1 with the macro, 0 without.
- Outputs take reset values immediately on rst assertion, without waiting for a clock.
- alu_ready and mem_ready are forced to 0 while rst=1.
- Latency: a handshake in cycle N gives wb_we/wb_addr/wb_data valid in cycle N+1, for exactly one cycle.
- Clear sweep:
  - wb_we is high for NREG consecutive cycles starting at the first edge after rst deasserts, addresses 0..NREG-1 in order.
  - busy falls together with the transition to RUN.
  - Readies may assert in the same cycle the address NREG-1 clear write is presented. The resulting write follows in the next cycle.
- Reset asserted mid-sweep or mid-transfer:
  - Any pending registered write is dropped (wb_we=0).
  - The sweep restarts from address 0 after deassertion.
- A requester holding valid while ready=0 sees no effect. Its request is not lost, because it must keep valid asserted.

## Configuration
- REGFILE_CLEAR_EN:
  - Defined: the CLEAR state and cnt exist, and reset enters the NREG-cycle zero sweep.
  - Undefined: no sweep and no counter. Reset enters RUN directly, busy is tied to 0, and the readies may assert in the first cycle after rst deasserts.

## Test plan
- Clear sweep (macro defined): deassert rst → wb_we=1 for 32 cycles with wb_addr 0..31 and wb_data=0, busy=1 throughout. alu_ready stays low until RUN.
- Single requester: alu_valid=1, alu_rd=5, alu_data=0x0000000A → alu_ready=1 in the same cycle. Next cycle: wb_we=1, wb_addr=5, wb_data=0xA. The following cycle wb_we=0 if alu_valid has dropped.
- Contention: both valid every cycle (ALU rd=6, MEM rd=7) → grants alternate ALU, MEM, ALU, MEM. wb_we stays high continuously, with wb_addr 6, 7, 6, 7.
- x0 drop: mem_valid=1, mem_rd=0, mem_data=0xFFFFFFFF → mem_ready pulses and wb_we stays 0. A following tie grants the ALU.
- Reset mid-sweep: assert rst at sweep address 12 → wb_we drops to 0 asynchronously. After release, the sweep restarts at address 0 and runs the full 32 cycles.
- Macro undefined: release rst with alu_valid=1 → alu_ready=1 in the first cycle after release, busy=0 always, and no zero writes are issued.
